uart_fifo_bridge: RTL and testbench

Buffered front-end between the CPU bus and the `uart` register block. It presents the same two-word bus port to the CPU (status at a0=0, data at a0=1), holds TX and RX bytes in internal FIFOs, and runs a small sequencer that drives the uart's bus port. The sequencer polls uart status, drains received bytes and feeds transmit bytes, so software no longer has to service every character at the bit rate.

---
 rtl/uart_fifo_bridge.sv | 153 +++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: buffered CPU front-end for the uart register block.
// Ports: clk, reset (sync, high); CPU bus din/dout/a0/rnw/cs_b;
//        uart bus u_din/u_dout/u_a0/u_rnw/u_cs_b.
// Option: define UART_FIFO_OVERRUN_EN to drop RX bytes into a full FIFO
//         and flag them in status bit13 (sticky, cleared by status read).
module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic        a0,
    input  logic        rnw,
    input  logic        cs_b,
    output logic [15:0] u_din,
    input  logic [15:0] u_dout,
    output logic        u_a0,
    output logic        u_rnw,
    output logic        u_cs_b
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POLL = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_WR   = 2'd3;

    logic [7:0] tx_mem_q [DEPTH];
    logic [7:0] rx_mem_q [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [DEPTH_LOG2-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic                  ovr_q, ovr_d;
    logic                  tx_idle_q, tx_idle_d;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic rx_in, rx_take, ovr_set, stat_rd, tx_done;
    logic [7:0] rx_head;
    logic unused_bits;

    assign unused_bits = ^{din[15:8], u_dout[13:8]};

    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);

    // Full is judged at the start of the cycle, so a same-cycle WR pop
    // does not rescue a write to a full TX FIFO.
    assign tx_push = !cs_b && a0 && !rnw && !tx_full;
    assign rx_pop  = !cs_b && a0 && rnw && !rx_empty;
    assign stat_rd = !cs_b && !a0 && rnw;
    assign tx_pop  = (state_q == ST_WR);
    assign rx_in   = (state_q == ST_RD);
    assign rx_push = rx_in && !rx_full;

`ifdef UART_FIFO_OVERRUN_EN
    assign rx_take = u_dout[14];
    assign ovr_set = rx_in && rx_full;
`else
    assign rx_take = u_dout[14] && !rx_full;
    assign ovr_set = 1'b0;
`endif

    assign tx_done = tx_empty && tx_idle_q;
    assign rx_head = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];

    always_comb begin
        if (a0) begin
            dout = {8'h00, rx_head};
        end else begin
            dout = {tx_full, !rx_empty, ovr_q, tx_done, 4'h0, 8'(rx_cnt_q)};
        end
    end

    assign u_cs_b = (state_q == ST_IDLE);
    assign u_a0   = (state_q == ST_RD) || (state_q == ST_WR);
    assign u_rnw  = (state_q != ST_WR);
    assign u_din  = (state_q == ST_WR) ? {8'h00, tx_mem_q[tx_rp_q]} : 16'h0000;

    always_comb begin
        state_d   = state_q;
        tx_idle_d = tx_idle_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_POLL;
            ST_POLL: begin
                tx_idle_d = !u_dout[15];
                if (rx_take) begin
                    state_d = ST_RD;
                end else if (!u_dout[15] && !tx_empty) begin
                    state_d = ST_WR;
                end
            end
            ST_RD:   state_d = ST_IDLE;
            ST_WR:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_wp_d  = tx_push ? tx_wp_q + PTR_ONE : tx_wp_q;
        tx_rp_d  = tx_pop  ? tx_rp_q + PTR_ONE : tx_rp_q;
        rx_wp_d  = rx_push ? rx_wp_q + PTR_ONE : rx_wp_q;
        rx_rp_d  = rx_pop  ? rx_rp_q + PTR_ONE : rx_rp_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CNT_ONE;
        if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT_ONE;
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + CNT_ONE;
        if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT_ONE;
        // A new overrun on the same edge as a status read stays visible.
        ovr_d = (ovr_q && !stat_rd) || ovr_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            ovr_q     <= 1'b0;
            tx_idle_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            ovr_q     <= ovr_d;
            tx_idle_q <= tx_idle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= din[7:0];
        if (rx_push) rx_mem_q[rx_wp_q] <= u_dout[7:0];
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: directed vector table plus multi-cycle sequences
// (RX fill/overrun, TX fill/drop, RX priority, reset during WR).
module tb_uart_fifo_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] din = 16'h0;
    logic [15:0] dout;
    logic        a0 = 1'b0;
    logic        rnw = 1'b1;
    logic        cs_b = 1'b1;
    logic [15:0] u_din;
    logic [15:0] u_dout;
    logic        u_a0, u_rnw, u_cs_b;
    logic [15:0] udout_drv = 16'h0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .din(din), .dout(dout),
        .a0(a0), .rnw(rnw), .cs_b(cs_b),
        .u_din(u_din), .u_dout(u_dout),
        .u_a0(u_a0), .u_rnw(u_rnw), .u_cs_b(u_cs_b)
    );

    // Simple uart model: one RX holding byte, busy for a few cycles after WR.
    logic       model_en = 1'b0;
    logic       hold_busy = 1'b0;
    logic       m_rx_full;
    logic [7:0] m_rx_byte;
    int         busy_cnt;
    logic [7:0] rx_q[$];
    logic [7:0] sent[$];
    int         rd_seen = 0;
    int         wr_seen = 0;

    assign u_dout = model_en ?
        {(hold_busy || busy_cnt != 0), m_rx_full, 6'b0, m_rx_byte} : udout_drv;

    always @(posedge clk) begin
        if (reset || !model_en) begin
            m_rx_full <= 1'b0;
            m_rx_byte <= 8'h00;
            busy_cnt  <= 0;
        end else begin
            if (!u_cs_b && u_a0 && u_rnw) begin
                m_rx_full <= 1'b0;
            end else if (!m_rx_full && rx_q.size() > 0) begin
                m_rx_byte <= rx_q.pop_front();
                m_rx_full <= 1'b1;
            end
            if (!u_cs_b && u_a0 && !u_rnw) begin
                sent.push_back(u_din[7:0]);
                busy_cnt <= 2;
            end else if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && !u_cs_b && u_a0 && u_rnw)  rd_seen <= rd_seen + 1;
        if (!reset && !u_cs_b && u_a0 && !u_rnw) wr_seen <= wr_seen + 1;
    end

    typedef struct {
        logic        cs_b;
        logic        a0;
        logic        rnw;
        logic [15:0] din;
        logic [15:0] udout;
        logic [15:0] dout;
        logic [2:0]  ucmd;
        logic [15:0] udin;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cs_b = 1'b1; a0 = 1'b0; rnw = 1'b1; din = 16'h0;
        model_en = 1'b0; hold_busy = 1'b0;
        rx_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cpu(input logic a, input logic r, input logic [15:0] d,
                       output logic [15:0] q);
        @(negedge clk);
        cs_b = 1'b0; a0 = a; rnw = r; din = d;
        #1 q = dout;
        @(posedge clk);
        #1;
        cs_b = 1'b1; a0 = 1'b0; rnw = 1'b1; din = 16'h0;
    endtask

    task automatic find_op(output bit found, output logic r,
                           output logic [15:0] d);
        found = 1'b0;
        r = 1'b1;
        d = 16'h0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            #1;
            if (!u_cs_b && u_a0) begin
                found = 1'b1;
                r = u_rnw;
                d = u_din;
            end
        end
    endtask

    initial begin
        logic [15:0] q;
        logic        r;
        logic [15:0] d;
        bit          f;
        int          base;
        logic [7:0]  b;

        //            cs  a0  rnw din     udout    dout     cmd     udin
        vecs[0]  = '{1'b0,1'b0,1'b1,16'h0000,16'h0000,16'h1000,3'b101,16'h0000};
        vecs[1]  = '{1'b1,1'b0,1'b1,16'h0000,16'h0000,16'h1000,3'b001,16'h0000};
        vecs[2]  = '{1'b0,1'b1,1'b0,16'h0041,16'h0000,16'h0000,3'b001,16'h0000};
        vecs[3]  = '{1'b0,1'b1,1'b0,16'h0042,16'h0000,16'h0000,3'b001,16'h0000};
        vecs[4]  = '{1'b1,1'b0,1'b1,16'h0000,16'h8000,16'h0000,3'b010,16'h0041};
        vecs[5]  = '{1'b1,1'b0,1'b1,16'h0000,16'h8000,16'h0000,3'b101,16'h0000};
        vecs[6]  = '{1'b1,1'b0,1'b1,16'h0000,16'h8000,16'h0000,3'b001,16'h0000};
        vecs[7]  = '{1'b1,1'b0,1'b1,16'h0000,16'h0000,16'h0000,3'b001,16'h0000};
        vecs[8]  = '{1'b1,1'b0,1'b1,16'h0000,16'h8000,16'h0000,3'b010,16'h0042};
        vecs[9]  = '{1'b1,1'b0,1'b1,16'h0000,16'h8000,16'h1000,3'b101,16'h0000};
        vecs[10] = '{1'b1,1'b0,1'b1,16'h0000,16'h8000,16'h1000,3'b001,16'h0000};
        vecs[11] = '{1'b1,1'b0,1'b1,16'h0000,16'h0000,16'h0000,3'b001,16'h0000};
        vecs[12] = '{1'b1,1'b0,1'b1,16'h0000,16'h0000,16'h1000,3'b001,16'h0000};
        vecs[13] = '{1'b1,1'b0,1'b1,16'h0000,16'hC05A,16'h1000,3'b001,16'h0000};
        vecs[14] = '{1'b1,1'b0,1'b1,16'h0000,16'hC05A,16'h0000,3'b011,16'h0000};
        vecs[15] = '{1'b1,1'b0,1'b1,16'h0000,16'h8000,16'h4001,3'b101,16'h0000};
        vecs[16] = '{1'b0,1'b1,1'b1,16'h0000,16'h8000,16'h005A,3'b001,16'h0000};
        vecs[17] = '{1'b0,1'b0,1'b1,16'h0000,16'h0000,16'h0000,3'b001,16'h0000};
        vecs[18] = '{1'b1,1'b0,1'b1,16'h0000,16'h0000,16'h1000,3'b001,16'h0000};
        vecs[19] = '{1'b0,1'b1,1'b1,16'h0000,16'h0000,16'h0000,3'b001,16'h0000};
        vecs[20] = '{1'b0,1'b0,1'b1,16'h0000,16'h0000,16'h1000,3'b001,16'h0000};

        // Table: reset state, TX path, RX path, empty read.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            cs_b = vecs[i].cs_b; a0 = vecs[i].a0; rnw = vecs[i].rnw;
            din = vecs[i].din; udout_drv = vecs[i].udout;
            #1;
            chk($sformatf("v%0d_dout", i), dout, vecs[i].dout);
            chk($sformatf("v%0d_ucmd", i), {13'h0, u_cs_b, u_a0, u_rnw},
                {13'h0, vecs[i].ucmd});
            chk($sformatf("v%0d_udin", i), u_din, vecs[i].udin);
            @(negedge clk);
        end
        cs_b = 1'b1; a0 = 1'b0; rnw = 1'b1; din = 16'h0; udout_drv = 16'h0;

        // RX fill: 16 bytes plus a 17th pending, uart TX held busy.
        do_reset();
        model_en = 1'b1;
        hold_busy = 1'b1;
        base = rd_seen;
        for (int i = 0; i < 17; i++) rx_q.push_back(8'h10 + 8'(i));
        repeat (100) @(negedge clk);
`ifdef UART_FIFO_OVERRUN_EN
        chk("rx_fill_rd_count", 16'(rd_seen - base), 16'd17);
        cpu(1'b0, 1'b1, 16'h0, q);
        chk("rx_fill_status_ovr", q, 16'h6010);
        cpu(1'b0, 1'b1, 16'h0, q);
        chk("rx_fill_status_clr", q, 16'h4010);
`else
        chk("rx_fill_rd_count", 16'(rd_seen - base), 16'd16);
        cpu(1'b0, 1'b1, 16'h0, q);
        chk("rx_fill_status", q, 16'h4010);
        cpu(1'b0, 1'b1, 16'h0, q);
        chk("rx_fill_status2", q, 16'h4010);
`endif
        for (int i = 0; i < 16; i++) begin
            b = 8'h10 + 8'(i);
            cpu(1'b1, 1'b1, 16'h0, q);
            chk($sformatf("rx_fill_data%0d", i), q, {8'h00, b});
        end
        repeat (10) @(negedge clk);
        cpu(1'b1, 1'b1, 16'h0, q);
`ifdef UART_FIFO_OVERRUN_EN
        chk("rx_fill_17th", q, 16'h0000);
`else
        chk("rx_fill_17th", q, 16'h0020);
`endif

        // TX fill: 16 writes, 17th (0xFF) dropped while uart busy.
        do_reset();
        model_en = 1'b1;
        hold_busy = 1'b1;
        base = sent.size();
        for (int i = 0; i < 16; i++) cpu(1'b1, 1'b0, 16'h0080 + 16'(i), q);
        cpu(1'b0, 1'b1, 16'h0, q);
        chk("tx_fill_status", q, 16'h8000);
        cpu(1'b1, 1'b0, 16'h00FF, q);
        cpu(1'b0, 1'b1, 16'h0, q);
        chk("tx_fill_status2", q, 16'h8000);
        hold_busy = 1'b0;
        for (int i = 0; i < 400 && sent.size() - base < 16; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("tx_sent_count", 16'(sent.size() - base), 16'd16);
        for (int i = 0; i < 16 && base + i < sent.size(); i++) begin
            b = 8'h80 + 8'(i);
            chk($sformatf("tx_sent%0d", i), {8'h00, sent[base + i]}, {8'h00, b});
        end
        cpu(1'b0, 1'b1, 16'h0, q);
        chk("tx_done_status", q, 16'h1000);

        // RX priority over TX, then reset in the middle of WR.
        do_reset();
        model_en = 1'b0;
        udout_drv = 16'h8000;
        cpu(1'b1, 1'b0, 16'h0033, q);
        repeat (2) @(negedge clk);
        udout_drv = 16'h4077;
        find_op(f, r, d);
        chk("prio_first_found", {15'h0, f}, 16'h0001);
        chk("prio_first_is_rd", {15'h0, r}, 16'h0001);
        @(posedge clk);
        #1 udout_drv = 16'h0000;
        find_op(f, r, d);
        chk("prio_second_is_wr", {14'h0, f, r}, 16'h0002);
        chk("prio_wr_data", d, 16'h0033);
        cpu(1'b1, 1'b1, 16'h0, q);
        chk("prio_rx_data", q, 16'h0077);
        udout_drv = 16'h8000;
        cpu(1'b1, 1'b0, 16'h0044, q);
        cpu(1'b1, 1'b0, 16'h0055, q);
        udout_drv = 16'h0000;
        find_op(f, r, d);
        chk("rst_wr_found", {14'h0, f, r}, 16'h0002);
        chk("rst_wr_data", d, 16'h0044);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ucmd", {13'h0, u_cs_b, u_a0, u_rnw}, 16'h0005);
        chk("rst_udin", u_din, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        base = wr_seen;
        repeat (10) @(negedge clk);
        chk("rst_no_wr", 16'(wr_seen - base), 16'd0);
        cpu(1'b0, 1'b1, 16'h0, q);
        chk("rst_status", q, 16'h1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
